// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-low {a,b,c,d,e,f,g}) and scan-reader FSM state encodings.
// The display-driver side uses the same tables.
package seg7_pkg;

    localparam logic [6:0] SEG7_CODE_0 = 7'b0000001;
    localparam logic [6:0] SEG7_CODE_1 = 7'b1001111;
    localparam logic [6:0] SEG7_CODE_2 = 7'b0010010;
    localparam logic [6:0] SEG7_CODE_3 = 7'b0000110;
    localparam logic [6:0] SEG7_CODE_4 = 7'b1001100;
    localparam logic [6:0] SEG7_CODE_5 = 7'b0100100;
    localparam logic [6:0] SEG7_CODE_6 = 7'b0100000;
    localparam logic [6:0] SEG7_CODE_7 = 7'b0001111;
    localparam logic [6:0] SEG7_CODE_8 = 7'b0000000;
    localparam logic [6:0] SEG7_CODE_9 = 7'b0000100;
    localparam logic [6:0] SEG7_CODE_A = 7'b0001000;
    localparam logic [6:0] SEG7_CODE_B = 7'b1100000;
    localparam logic [6:0] SEG7_CODE_C = 7'b0110001;
    localparam logic [6:0] SEG7_CODE_D = 7'b1000010;
    localparam logic [6:0] SEG7_CODE_E = 7'b0110000;
    localparam logic [6:0] SEG7_CODE_F = 7'b0111000;
    localparam logic [6:0] SEG7_BLANK  = 7'b1111111;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse 7-segment LUT: active-low segment code -> hex nibble.
// Unknown codes (blank included) decode to 0 with dig_err set.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] code,
    output logic [3:0] nibble,
    output logic       dig_err
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch can be inferred.
        nibble  = 4'h0;
        dig_err = 1'b0;
        case (code)
            SEG7_CODE_0: nibble = 4'h0;
            SEG7_CODE_1: nibble = 4'h1;
            SEG7_CODE_2: nibble = 4'h2;
            SEG7_CODE_3: nibble = 4'h3;
            SEG7_CODE_4: nibble = 4'h4;
            SEG7_CODE_5: nibble = 4'h5;
            SEG7_CODE_6: nibble = 4'h6;
            SEG7_CODE_7: nibble = 4'h7;
            SEG7_CODE_8: nibble = 4'h8;
            SEG7_CODE_9: nibble = 4'h9;
            SEG7_CODE_A: nibble = 4'hA;
            SEG7_CODE_B: nibble = 4'hB;
            SEG7_CODE_C: nibble = 4'hC;
            SEG7_CODE_D: nibble = 4'hD;
            SEG7_CODE_E: nibble = 4'hE;
            SEG7_CODE_F: nibble = 4'hF;
            SEG7_BLANK:  dig_err = 1'b1;
            default:     dig_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus after a stable dwell.
// Define SEG7_DP_EN to also capture the decimal point (dp in, dp_out out).
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int NUM_DIGITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
`ifdef SEG7_DP_EN
    input  logic                    dp,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic [NUM_DIGITS-1:0]   cap_mask
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
`ifdef SEG7_DP_EN
    localparam int DPW = 1;
`else
    localparam int DPW = 0;
`endif
    localparam int SW = NUM_DIGITS + 7 + DPW;

    logic [6:0]              seg_m, s_seg;
    logic [NUM_DIGITS-1:0]   an_m, s_an;
    logic [SW-1:0]           sample, ref_s;
    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] dig, dig_next;
    logic                    err_pend;
    logic [3:0]              nibble;
    logic                    dig_err;
    logic                    an_onehot, capture, frame_done;
    logic [NUM_DIGITS-1:0]   cap_sel, mask_next;
`ifdef SEG7_DP_EN
    logic                    dp_m, s_dp;
    logic [NUM_DIGITS-1:0]   dp_dig, dp_dig_next;
`endif

    seg7_to_hex u_dec (
        .code    (s_seg),
        .nibble  (nibble),
        .dig_err (dig_err)
    );

    always_comb begin
`ifdef SEG7_DP_EN
        sample = {s_an, s_seg, s_dp};
`else
        sample = {s_an, s_seg};
`endif
        an_onehot  = $onehot(~s_an);
        cap_sel    = ~s_an;
        // A stable sample equal to ref_s is one-hot by construction, so cap_sel picks exactly one digit.
        capture    = !clr && (state == S_COUNT) && (sample == ref_s) && (cnt == CNT_LAST);
        mask_next  = cap_mask | cap_sel;
        frame_done = capture && (&mask_next);
        dig_next   = dig;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_sel[i]) dig_next[4*i +: 4] = nibble;
        end
`ifdef SEG7_DP_EN
        dp_dig_next = dp_dig;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_sel[i]) dp_dig_next[i] = ~s_dp;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch; every register, data included, is cleared.
        if (rst) begin
            seg_m       <= '1;
            s_seg       <= '1;
            an_m        <= '1;
            s_an        <= '1;
            ref_s       <= '1;
            state       <= S_WAIT;
            cnt         <= '0;
            dig         <= '0;
            err_pend    <= 1'b0;
            cap_mask    <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
`ifdef SEG7_DP_EN
            dp_m        <= 1'b1;
            s_dp        <= 1'b1;
            dp_dig      <= '0;
            dp_out      <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge values.
            seg_m       <= seg;
            s_seg       <= seg_m;
            an_m        <= an;
            s_an        <= an_m;
`ifdef SEG7_DP_EN
            dp_m        <= dp;
            s_dp        <= dp_m;
`endif
            frame_valid <= 1'b0;

            if (clr) begin
                cap_mask <= '0;
                err_pend <= 1'b0;
                state    <= S_WAIT;
                cnt      <= '0;
            end else begin
                case (state)
                    S_COUNT: begin
                        if (sample != ref_s) begin
                            if (an_onehot) begin
                                ref_s <= sample;
                                cnt   <= CW'(1);
                            end else begin
                                state <= S_WAIT;
                                cnt   <= '0;
                            end
                        end else if (cnt == CNT_LAST) begin
                            state <= S_HOLD;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        // S_WAIT always looks for a new sample; S_HOLD only once the bus moves.
                        if (state == S_WAIT || sample != ref_s) begin
                            if (an_onehot) begin
                                ref_s <= sample;
                                cnt   <= CW'(1);
                                state <= S_COUNT;
                            end else begin
                                state <= S_WAIT;
                                cnt   <= '0;
                            end
                        end
                    end
                endcase

                if (capture) begin
                    dig <= dig_next;
`ifdef SEG7_DP_EN
                    dp_dig <= dp_dig_next;
`endif
                    if (frame_done) begin
                        value       <= dig_next;
                        frame_err   <= err_pend | dig_err;
                        frame_valid <= 1'b1;
                        cap_mask    <= '0;
                        err_pend    <= 1'b0;
`ifdef SEG7_DP_EN
                        dp_out      <= dp_dig_next;
`endif
                    end else begin
                        cap_mask <= mask_next;
                        err_pend <= err_pend | dig_err;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: directed scenarios plus random bus traffic
// compared every cycle against a run-length reference model.
module tb_seg7_scan_reader;

    localparam int S  = 16;
    localparam int ND = 4;

    localparam logic [6:0] CODES [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } pin_t;

    logic        clk = 1'b0;
    logic        rst, clr, dp;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic        frame_valid, frame_err;
    logic [3:0]  cap_mask;
`ifdef SEG7_DP_EN
    logic [3:0]  dp_out;
`endif

    always #5 clk = ~clk;

    seg7_scan_reader #(.STABLE_CYCLES(S), .NUM_DIGITS(ND)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
`ifdef SEG7_DP_EN
        .dp          (dp),
        .dp_out      (dp_out),
`endif
        .clr         (clr),
        .value       (value),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .cap_mask    (cap_mask)
    );

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    bit chk_en = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    pin_t        q[$];
    pin_t        run_val;
    int          run_len;
    bit          run_done;
    logic [3:0]  m_dig [4];
    logic        m_dpd [4];
    logic [3:0]  m_mask;
    logic        m_errp, m_err, m_fv;
    logic [15:0] m_value;
    logic [3:0]  m_dpout;

    function automatic bit same(input pin_t a, input pin_t b);
`ifdef SEG7_DP_EN
        return a == b;
`else
        return (a.an == b.an) && (a.seg == b.seg);
`endif
    endfunction

    function automatic int low_count(input logic [3:0] a);
        int z = 0;
        for (int i = 0; i < 4; i++) if (a[i] == 1'b0) z++;
        return z;
    endfunction

    function automatic int low_idx(input logic [3:0] a);
        int k = 0;
        for (int i = 0; i < 4; i++) if (a[i] == 1'b0) k = i;
        return k;
    endfunction

    task automatic decode(input logic [6:0] c, output logic [3:0] n, output logic e);
        n = 4'h0;
        e = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (CODES[i] == c) begin
                n = i[3:0];
                e = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        q.push_back('{4'hF, 7'h7F, 1'b1});
        q.push_back('{4'hF, 7'h7F, 1'b1});
        run_len  = 0;
        run_done = 0;
        run_val  = '1;
        for (int i = 0; i < 4; i++) begin
            m_dig[i] = 4'h0;
            m_dpd[i] = 1'b0;
        end
        m_mask  = 4'h0;
        m_errp  = 1'b0;
        m_err   = 1'b0;
        m_fv    = 1'b0;
        m_value = 16'h0;
        m_dpout = 4'h0;
    endtask

    task automatic model_capture(input pin_t p);
        int         d;
        logic [3:0] n;
        logic       e;
        logic [3:0] nm;
        d = low_idx(p.an);
        decode(p.seg, n, e);
        m_dig[d] = n;
        m_dpd[d] = ~p.dp;
        nm = m_mask | (4'b0001 << d);
        if (nm == 4'hF) begin
            m_value = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
            m_err   = m_errp | e;
            m_fv    = 1'b1;
            m_dpout = {m_dpd[3], m_dpd[2], m_dpd[1], m_dpd[0]};
            m_mask  = 4'h0;
            m_errp  = 1'b0;
        end else begin
            m_mask = nm;
            m_errp = m_errp | e;
        end
    endtask

    // The decision logic sees the pins two clocks late; a one-hot run of S identical samples captures once.
    task automatic model_step();
        pin_t cur, seen;
        cur = '{an, seg, dp};
        if (rst) begin
            model_reset();
            return;
        end
        seen = q.pop_front();
        q.push_back(cur);
        m_fv = 1'b0;
        if (clr) begin
            m_mask   = 4'h0;
            m_errp   = 1'b0;
            run_len  = 0;
            run_done = 0;
        end else if (low_count(seen.an) == 1) begin
            if (run_len > 0 && same(seen, run_val)) begin
                run_len++;
            end else begin
                run_val  = seen;
                run_len  = 1;
                run_done = 0;
            end
            if (run_len == S && !run_done) begin
                run_done = 1;
                model_capture(seen);
            end
        end else begin
            run_len = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (frame_valid === 1'b1) fv_cnt++;
                check("frame_valid", frame_valid, m_fv);
                check("cap_mask", cap_mask, m_mask);
                check("value", value, m_value);
                check("frame_err", frame_err, m_err);
`ifdef SEG7_DP_EN
                check("dp_out", dp_out, m_dpout);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an  = a;
        seg = s;
        dp  = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        hold(4'hF, 7'h7F, 1'b1, n);
    endtask

    task automatic sweep(input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                         input logic [6:0] c3, input logic [3:0] dpn, input int n);
        hold(4'b1110, c0, dpn[0], n);
        hold(4'b1101, c1, dpn[1], n);
        hold(4'b1011, c2, dpn[2], n);
        hold(4'b0111, c3, dpn[3], n);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int f0;
        logic [3:0] a;
        logic [6:0] s;

        rst = 1'b1;
        clr = 1'b0;
        an  = 4'hF;
        seg = 7'h7F;
        dp  = 1'b1;
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_value", value, 16'h0);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_cap_mask", cap_mask, 4'h0);
        rst = 1'b0;

        // Clean sweep 0,1,2,3.
        f0 = fv_cnt;
        sweep(CODES[0], CODES[1], CODES[2], CODES[3], 4'hF, 20);
        idle(4);
        #1;
        check("t1_pulses", fv_cnt - f0, 1);
        check("t1_value", value, 16'h3210);
        check("t1_frame_err", frame_err, 1'b0);
        check("t1_cap_mask", cap_mask, 4'h0);

        // Dwell boundary: S-1 synced samples do not capture, S samples do.
        hold(4'b1110, CODES[1], 1'b1, S - 1);
        idle(5);
        #1;
        check("t2_short_mask", cap_mask, 4'h0);
        hold(4'b1110, CODES[1], 1'b1, S);
        idle(5);
        #1;
        check("t2_exact_mask", cap_mask, 4'b0001);
        pulse_clr();
        idle(2);
        #1;
        check("t2_clr_mask", cap_mask, 4'h0);

        // Undecodable digit 2, then a clean frame clears frame_err.
        f0 = fv_cnt;
        sweep(CODES[0], CODES[1], 7'b1111110, CODES[3], 4'hF, 20);
        idle(4);
        #1;
        check("t3_pulses", fv_cnt - f0, 1);
        check("t3_value", value, 16'h3010);
        check("t3_frame_err", frame_err, 1'b1);
        sweep(CODES[0], CODES[1], CODES[2], CODES[3], 4'hF, 20);
        idle(4);
        #1;
        check("t3_clean_err", frame_err, 1'b0);
        check("t3_clean_value", value, 16'h3210);

        // Two anodes low never qualify.
        hold(4'b1100, CODES[0], 1'b1, 50);
        idle(4);
        #1;
        check("t4_multi_mask", cap_mask, 4'h0);
        hold(4'b1110, CODES[5], 1'b1, 20);
        idle(4);
        #1;
        check("t4_single_mask", cap_mask, 4'b0001);
        pulse_clr();

        // clr drops partial captures but keeps value.
        hold(4'b1110, CODES[7], 1'b1, 20);
        hold(4'b1101, CODES[8], 1'b1, 20);
        idle(4);
        #1;
        check("t5_partial_mask", cap_mask, 4'b0011);
        pulse_clr();
        idle(2);
        #1;
        check("t5_clr_mask", cap_mask, 4'h0);
        check("t5_clr_value", value, 16'h3210);
        f0 = fv_cnt;
        hold(4'b1011, CODES[9], 1'b1, 20);
        hold(4'b0111, CODES[10], 1'b1, 20);
        idle(4);
        #1;
        check("t5_half_pulses", fv_cnt - f0, 0);
        check("t5_half_mask", cap_mask, 4'b1100);
        hold(4'b1110, CODES[11], 1'b1, 20);
        hold(4'b1101, CODES[12], 1'b1, 20);
        idle(4);
        #1;
        check("t5_full_pulses", fv_cnt - f0, 1);
        check("t5_full_value", value, 16'hA9CB);

        // Reset mid-count.
        hold(4'b1110, CODES[4], 1'b1, 20);
        hold(4'b1101, CODES[6], 1'b1, 8);
        rst = 1'b1;
        hold(4'b1101, CODES[6], 1'b1, 2);
        #1;
        check("t5_rst_value", value, 16'h0);
        check("t5_rst_err", frame_err, 1'b0);
        check("t5_rst_mask", cap_mask, 4'h0);
        check("t5_rst_fv", frame_valid, 1'b0);
        rst = 1'b0;
        f0 = fv_cnt;
        idle(30);
        #1;
        check("t5_post_rst_pulses", fv_cnt - f0, 0);
        check("t5_post_rst_mask", cap_mask, 4'h0);

        // Decimal point on digit 3 only.
        sweep(CODES[0], CODES[1], CODES[2], CODES[3], 4'b0111, 20);
        idle(4);
        #1;
        check("t6_value", value, 16'h3210);
`ifdef SEG7_DP_EN
        check("t6_dp_out", dp_out, 4'b1000);
`endif

        // Random bus traffic against the model.
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 99) < 85) a = ~(4'b0001 << $urandom_range(0, 3));
            else                            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 80) s = CODES[$urandom_range(0, 15)];
            else                            s = 7'($urandom_range(0, 127));
            hold(a, s, 1'($urandom_range(0, 1)), $urandom_range(1, 24));
            if ($urandom_range(0, 99) < 5) pulse_clr();
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
